// File: rtl/sync_counter_pkg.sv
// Shared definitions for the modulo-N up/down counter family.
package sync_counter_pkg;

    // Default counter width used when the parent does not override WIDTH.
    localparam int unsigned DEFAULT_WIDTH = 4;

    // RUN counts normally; DONE parks the counter after a one-shot terminal event.
    typedef enum logic {
        CNT_RUN  = 1'b0,
        CNT_DONE = 1'b1
    } cnt_state_t;

endpackage

// File: rtl/cnt_next_val.sv
// Combinational next-count computation for a modulo-MODULUS up/down counter.
// Reports the wrapped next value and whether the current value is terminal
// for the selected direction.
module cnt_next_val
    import sync_counter_pkg::*;
#(
    parameter int unsigned     WIDTH   = DEFAULT_WIDTH,
    parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
    input  logic [WIDTH-1:0] count,
    input  logic             up,
    output logic [WIDTH-1:0] next_count,
    output logic             at_terminal
);

    // Largest legal count value; MODULUS may be 2**32, so it is held in 64 bits.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'd1);

    // Terminal detection and wrap: MAX_VAL -> 0 going up, 0 -> MAX_VAL going down.
    always_comb begin
        next_count  = count;
        at_terminal = 1'b0;
        if (up) begin
            at_terminal = (count == MAX_VAL);
            next_count  = at_terminal ? '0 : count + WIDTH'(1);
        end else begin
            at_terminal = (count == '0);
            next_count  = at_terminal ? MAX_VAL : count - WIDTH'(1);
        end
    end

endmodule

// File: rtl/sync_counter_n.sv
// Modulo-MODULUS synchronous up/down counter with clear, preset, parallel
// load, one-shot stop at terminal count and a combinational cascade output.
module sync_counter_n
    import sync_counter_pkg::*;
#(
    parameter int unsigned     WIDTH   = DEFAULT_WIDTH,
    parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             prs,
    input  logic             cten,
    input  logic             up,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    input  logic             oneshot,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             done
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'd1);

    cnt_state_t       state;
    cnt_state_t       state_nxt;
    logic [WIDTH-1:0] out_nxt;
    logic [WIDTH-1:0] count_next;
    logic [WIDTH-1:0] load_val;
    logic             at_terminal;
    logic             count_en;
    logic             done_nxt;

    cnt_next_val #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next (
        .count       (out),
        .up          (up),
        .next_count  (count_next),
        .at_terminal (at_terminal)
    );

    // Out-of-range load values saturate to the top of the count range so
    // the register can never hold a value >= MODULUS.
    assign load_val = (64'(d) < MODULUS) ? d : MAX_VAL;

    // Priority clr > prs > ld > count > hold; also the zero-latency tc gating.
    always_comb begin
        out_nxt   = out;
        state_nxt = state;
        count_en  = cten && (state == CNT_RUN) && !clr && !prs && !ld;
        tc        = count_en && at_terminal;
        if (clr) begin
            out_nxt   = '0;
            state_nxt = CNT_RUN;
        end else if (prs) begin
            out_nxt   = MAX_VAL;
            state_nxt = CNT_RUN;
        end else if (ld) begin
            out_nxt   = load_val;
            state_nxt = CNT_RUN;
        end else if (count_en) begin
            if (at_terminal && oneshot) begin
                state_nxt = CNT_DONE;
            end else begin
                out_nxt = count_next;
            end
        end
        done_nxt = (state_nxt == CNT_DONE);
    end

    // Count, state and done registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            out   <= '0;
            state <= CNT_RUN;
            done  <= 1'b0;
        end else begin
            out   <= out_nxt;
            state <= state_nxt;
            done  <= done_nxt;
        end
    end

endmodule

// File: tb/tb_sync_counter_n.sv
// Self-checking bench for sync_counter_n: modulo-10 main instance, a two-stage
// cascade and an 8-bit default-modulus instance.
module tb_sync_counter_n;

    typedef struct packed {
        logic [7:0] out;
        logic       done;
    } exp_t;

    typedef struct packed {
        logic       c;
        logic       p;
        logic       l;
        logic [3:0] dv;
        logic       ce;
        logic       u;
        logic       os;
        logic       etc;
        logic [3:0] eq;
        logic       edn;
    } row_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clr, prs, ld, cten, up, oneshot;
    logic [3:0] d;
    logic [3:0] out;
    logic       tc, done;

    logic       c_clr, c_cten;
    logic [3:0] lo_out, hi_out;
    logic       lo_tc, hi_tc, lo_done, hi_done;

    logic       w_clr, w_cten, w_up;
    logic [7:0] w_out;
    logic       w_tc, w_done;

    int   checks = 0;
    int   passed = 0;
    exp_t sb[$];

    sync_counter_n #(.WIDTH(4), .MODULUS(10)) dut (
        .clk(clk), .clr(clr), .prs(prs), .cten(cten), .up(up), .ld(ld),
        .d(d), .oneshot(oneshot), .out(out), .tc(tc), .done(done)
    );

    sync_counter_n #(.WIDTH(4), .MODULUS(10)) lo (
        .clk(clk), .clr(c_clr), .prs(1'b0), .cten(c_cten), .up(1'b1), .ld(1'b0),
        .d(4'd0), .oneshot(1'b0), .out(lo_out), .tc(lo_tc), .done(lo_done)
    );

    sync_counter_n #(.WIDTH(4), .MODULUS(10)) hi (
        .clk(clk), .clr(c_clr), .prs(1'b0), .cten(lo_tc), .up(1'b1), .ld(1'b0),
        .d(4'd0), .oneshot(1'b0), .out(hi_out), .tc(hi_tc), .done(hi_done)
    );

    sync_counter_n #(.WIDTH(8)) wide (
        .clk(clk), .clr(w_clr), .prs(1'b0), .cten(w_cten), .up(w_up), .ld(1'b0),
        .d(8'd0), .oneshot(1'b0), .out(w_out), .tc(w_tc), .done(w_done)
    );

    // Drives the main instance's inputs away from the rising edge.
    task automatic drive(input logic c, p, l, input logic [3:0] dv, input logic ce, u, os);
        @(negedge clk);
        clr = c; prs = p; ld = l; d = dv; cten = ce; up = u; oneshot = os;
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        drive(1'b1, 1'b1, 1'b1, 4'd6, 1'b1, 1'b1, 1'b0);
        checks++;
        if (tc !== 1'b0) $display("[TB] FAIL reset_tc: got %b expected 0", tc);
        else passed++;
        sb.push_back('{out: 8'd0, done: 1'b0});
        @(posedge clk); #1;
        e = sb.pop_front();
        checks++;
        if (out !== e.out[3:0] || done !== e.done)
            $display("[TB] FAIL reset_state: got out=%0d done=%b expected out=%0d done=%b", out, done, e.out, e.done);
        else passed++;
    endtask

    task automatic test_count_up();
        exp_t       e;
        logic [3:0] m;
        m = 4'd0;
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
            checks++;
            if (tc !== (m == 4'd9)) $display("[TB] FAIL count_up_tc step %0d: got %b expected %b", i, tc, m == 4'd9);
            else passed++;
            m = (m == 4'd9) ? 4'd0 : m + 4'd1;
            sb.push_back('{out: {4'd0, m}, done: 1'b0});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (out !== e.out[3:0] || done !== e.done)
                $display("[TB] FAIL count_up step %0d: got out=%0d done=%b expected out=%0d done=%b", i, out, done, e.out, e.done);
            else passed++;
        end
    endtask

    task automatic test_count_down();
        exp_t e;
        row_t tbl [0:4] = '{
            '{1'b0,1'b0,1'b1,4'd3,1'b1,1'b0,1'b0, 1'b0,4'd3,1'b0},
            '{1'b0,1'b0,1'b0,4'd0,1'b1,1'b0,1'b0, 1'b0,4'd2,1'b0},
            '{1'b0,1'b0,1'b0,4'd0,1'b1,1'b0,1'b0, 1'b0,4'd1,1'b0},
            '{1'b0,1'b0,1'b0,4'd0,1'b1,1'b0,1'b0, 1'b0,4'd0,1'b0},
            '{1'b0,1'b0,1'b0,4'd0,1'b1,1'b0,1'b0, 1'b1,4'd9,1'b0}
        };
        foreach (tbl[i]) begin
            drive(tbl[i].c, tbl[i].p, tbl[i].l, tbl[i].dv, tbl[i].ce, tbl[i].u, tbl[i].os);
            checks++;
            if (tc !== tbl[i].etc) $display("[TB] FAIL count_down_tc row %0d: got %b expected %b", i, tc, tbl[i].etc);
            else passed++;
            sb.push_back('{out: {4'd0, tbl[i].eq}, done: tbl[i].edn});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (out !== e.out[3:0] || done !== e.done)
                $display("[TB] FAIL count_down row %0d: got out=%0d done=%b expected out=%0d done=%b", i, out, done, e.out, e.done);
            else passed++;
        end
    endtask

    task automatic test_oneshot();
        exp_t e;
        row_t tbl [0:6] = '{
            '{1'b0,1'b0,1'b1,4'd7,1'b1,1'b1,1'b1, 1'b0,4'd7,1'b0},
            '{1'b0,1'b0,1'b0,4'd0,1'b1,1'b1,1'b1, 1'b0,4'd8,1'b0},
            '{1'b0,1'b0,1'b0,4'd0,1'b1,1'b1,1'b1, 1'b0,4'd9,1'b0},
            '{1'b0,1'b0,1'b0,4'd0,1'b1,1'b1,1'b1, 1'b1,4'd9,1'b1},
            '{1'b0,1'b0,1'b0,4'd0,1'b1,1'b1,1'b1, 1'b0,4'd9,1'b1},
            '{1'b0,1'b0,1'b0,4'd0,1'b1,1'b0,1'b1, 1'b0,4'd9,1'b1},
            '{1'b0,1'b0,1'b1,4'd2,1'b1,1'b1,1'b1, 1'b0,4'd2,1'b0}
        };
        foreach (tbl[i]) begin
            drive(tbl[i].c, tbl[i].p, tbl[i].l, tbl[i].dv, tbl[i].ce, tbl[i].u, tbl[i].os);
            checks++;
            if (tc !== tbl[i].etc) $display("[TB] FAIL oneshot_tc row %0d: got %b expected %b", i, tc, tbl[i].etc);
            else passed++;
            sb.push_back('{out: {4'd0, tbl[i].eq}, done: tbl[i].edn});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (out !== e.out[3:0] || done !== e.done)
                $display("[TB] FAIL oneshot row %0d: got out=%0d done=%b expected out=%0d done=%b", i, out, done, e.out, e.done);
            else passed++;
        end
    endtask

    task automatic test_priority();
        exp_t e;
        row_t tbl [0:10] = '{
            '{1'b0,1'b0,1'b1,4'd12,1'b0,1'b1,1'b0, 1'b0,4'd9,1'b0},
            '{1'b0,1'b0,1'b1,4'd4, 1'b0,1'b1,1'b0, 1'b0,4'd4,1'b0},
            '{1'b0,1'b1,1'b1,4'd3, 1'b0,1'b1,1'b0, 1'b0,4'd9,1'b0},
            '{1'b0,1'b0,1'b1,4'd4, 1'b0,1'b1,1'b0, 1'b0,4'd4,1'b0},
            '{1'b1,1'b1,1'b1,4'd5, 1'b1,1'b1,1'b0, 1'b0,4'd0,1'b0},
            '{1'b0,1'b0,1'b0,4'd0, 1'b1,1'b1,1'b0, 1'b0,4'd1,1'b0},
            '{1'b0,1'b1,1'b0,4'd0, 1'b0,1'b1,1'b1, 1'b0,4'd9,1'b0},
            '{1'b0,1'b0,1'b0,4'd0, 1'b1,1'b1,1'b1, 1'b1,4'd9,1'b1},
            '{1'b0,1'b1,1'b0,4'd0, 1'b1,1'b1,1'b1, 1'b0,4'd9,1'b0},
            '{1'b0,1'b0,1'b0,4'd0, 1'b1,1'b1,1'b1, 1'b1,4'd9,1'b1},
            '{1'b1,1'b0,1'b0,4'd0, 1'b1,1'b1,1'b1, 1'b0,4'd0,1'b0}
        };
        foreach (tbl[i]) begin
            drive(tbl[i].c, tbl[i].p, tbl[i].l, tbl[i].dv, tbl[i].ce, tbl[i].u, tbl[i].os);
            checks++;
            if (tc !== tbl[i].etc) $display("[TB] FAIL priority_tc row %0d: got %b expected %b", i, tc, tbl[i].etc);
            else passed++;
            sb.push_back('{out: {4'd0, tbl[i].eq}, done: tbl[i].edn});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (out !== e.out[3:0] || done !== e.done)
                $display("[TB] FAIL priority row %0d: got out=%0d done=%b expected out=%0d done=%b", i, out, done, e.out, e.done);
            else passed++;
        end
    endtask

    task automatic test_reverse();
        exp_t e;
        row_t tbl [0:5] = '{
            '{1'b0,1'b0,1'b0,4'd0,1'b1,1'b1,1'b0, 1'b0,4'd1,1'b0},
            '{1'b0,1'b0,1'b0,4'd0,1'b0,1'b1,1'b0, 1'b0,4'd1,1'b0},
            '{1'b0,1'b0,1'b0,4'd0,1'b1,1'b1,1'b0, 1'b0,4'd2,1'b0},
            '{1'b0,1'b0,1'b0,4'd0,1'b1,1'b0,1'b0, 1'b0,4'd1,1'b0},
            '{1'b0,1'b0,1'b0,4'd0,1'b1,1'b0,1'b0, 1'b0,4'd0,1'b0},
            '{1'b0,1'b0,1'b0,4'd0,1'b1,1'b0,1'b0, 1'b1,4'd9,1'b0}
        };
        foreach (tbl[i]) begin
            drive(tbl[i].c, tbl[i].p, tbl[i].l, tbl[i].dv, tbl[i].ce, tbl[i].u, tbl[i].os);
            checks++;
            if (tc !== tbl[i].etc) $display("[TB] FAIL reverse_tc row %0d: got %b expected %b", i, tc, tbl[i].etc);
            else passed++;
            sb.push_back('{out: {4'd0, tbl[i].eq}, done: tbl[i].edn});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (out !== e.out[3:0] || done !== e.done)
                $display("[TB] FAIL reverse row %0d: got out=%0d done=%b expected out=%0d done=%b", i, out, done, e.out, e.done);
            else passed++;
        end
    endtask

    task automatic test_cascade();
        exp_t e;
        @(negedge clk);
        c_clr = 1'b1; c_cten = 1'b0;
        sb.push_back('{out: 8'h00, done: 1'b0});
        @(posedge clk); #1;
        e = sb.pop_front();
        checks++;
        if ({hi_out, lo_out} !== e.out)
            $display("[TB] FAIL cascade_clear: got hi/lo=%0d/%0d expected 0/0", hi_out, lo_out);
        else passed++;
        @(negedge clk);
        c_clr = 1'b0; c_cten = 1'b1;
        for (int n = 1; n <= 25; n++) begin
            sb.push_back('{out: {4'(n / 10), 4'(n % 10)}, done: 1'b0});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({hi_out, lo_out} !== e.out)
                $display("[TB] FAIL cascade edge %0d: got hi/lo=%0d/%0d expected %0d/%0d", n, hi_out, lo_out, e.out[7:4], e.out[3:0]);
            else passed++;
        end
        @(negedge clk);
        c_cten = 1'b0;
    endtask

    task automatic test_wide();
        exp_t e;
        @(negedge clk);
        w_clr = 1'b1; w_cten = 1'b0; w_up = 1'b1;
        sb.push_back('{out: 8'd0, done: 1'b0});
        @(posedge clk); #1;
        e = sb.pop_front();
        checks++;
        if (w_out !== e.out || w_done !== e.done)
            $display("[TB] FAIL wide_clear: got out=%0d done=%b expected 0/0", w_out, w_done);
        else passed++;
        @(negedge clk);
        w_clr = 1'b0; w_cten = 1'b1; w_up = 1'b0;
        #1;
        checks++;
        if (w_tc !== 1'b1) $display("[TB] FAIL wide_tc_at_zero: got %b expected 1", w_tc);
        else passed++;
        sb.push_back('{out: 8'd255, done: 1'b0});
        sb.push_back('{out: 8'd254, done: 1'b0});
        @(posedge clk); #1;
        e = sb.pop_front();
        checks++;
        if (w_out !== e.out) $display("[TB] FAIL wide_wrap: got %0d expected %0d", w_out, e.out);
        else passed++;
        checks++;
        if (w_tc !== 1'b0) $display("[TB] FAIL wide_tc_at_255: got %b expected 0", w_tc);
        else passed++;
        @(posedge clk); #1;
        e = sb.pop_front();
        checks++;
        if (w_out !== e.out) $display("[TB] FAIL wide_down: got %0d expected %0d", w_out, e.out);
        else passed++;
    endtask

    // Safety net in case the run stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit, got %0d/%0d", passed, checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clr = 1'b0; prs = 1'b0; ld = 1'b0; cten = 1'b0; up = 1'b1; oneshot = 1'b0; d = 4'd0;
        c_clr = 1'b1; c_cten = 1'b0;
        w_clr = 1'b1; w_cten = 1'b0; w_up = 1'b1;
        test_reset();
        test_count_up();
        test_count_down();
        test_oneshot();
        test_priority();
        test_reverse();
        test_cascade();
        test_wide();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
